// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: state encoding, mode bit
// positions and the default word width.
package spi_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    SETUP = S_SETUP,
    XFER  = S_XFER,
    HOLD  = S_HOLD,
    GAP   = S_GAP
  } state_t;

  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one divider tick per SCLK half-period, MSB-first
// transmit with simultaneous receive, chip-select framing with a guard gap.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  input  logic                  i_miso
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(EDGES);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

  state_t                state;
  logic [1:0]            mode;
  logic [EW-1:0]         edge_cnt;
  logic [DATA_WIDTH-1:0] tx;
  logic [DATA_WIDTH-1:0] rx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      mode     <= 2'b00;
      edge_cnt <= '0;
      tx       <= '0;
      rx       <= '0;
      o_ready  <= 1'b0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_cs_n   <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            tx              <= i_data;
            mode[MODE_CPOL] <= i_cpol;
            mode[MODE_CPHA] <= i_cpha;
            edge_cnt        <= '0;
            o_sclk          <= i_cpol;
            o_cs_n          <= 1'b0;
            o_busy          <= 1'b1;
            o_ready         <= 1'b0;
            // CPHA=0 presents the MSB before the first (leading) edge.
            if (!i_cpha) o_mosi <= i_data[DATA_WIDTH-1];
            state           <= SETUP;
          end
        end
        SETUP: begin
          if (i_tick) state <= XFER;
        end
        XFER: begin
          if (i_tick) begin
            o_sclk <= ~o_sclk;
            // Sampling edges are the even ones for CPHA=0, odd ones for CPHA=1.
            if (edge_cnt[0] == mode[MODE_CPHA]) begin
              rx <= {rx[DATA_WIDTH-2:0], i_miso};
            end else begin
              o_mosi <= mode[MODE_CPHA] ? tx[DATA_WIDTH-1] : tx[DATA_WIDTH-2];
              tx     <= tx << 1;
            end
            if (edge_cnt == LAST_EDGE) begin
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + EW'(1);
            end
          end
        end
        HOLD: begin
          if (i_tick) begin
            o_cs_n  <= 1'b1;
            o_data  <= rx;
            o_valid <= 1'b1;
            state   <= GAP;
          end
        end
        GAP: begin
          if (i_tick) begin
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
            o_sclk  <= mode[MODE_CPOL];
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: an SPI slave model reacting to the pins, checked
// against the words exchanged, plus framing and timing checks.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         cpol, cpha;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         busy;
  logic         sclk, mosi, cs_n;
  logic         miso;
  logic         slave_miso;
  logic         loopback;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_mode = 0;
  int tick_cnt = 0;
  int phase = 0;
  int eff_rise = 0;
  bit have_rise = 0;

  assign miso = loopback ? mosi : slave_miso;

  spi_shift_engine #(.DATA_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_cpol(cpol), .i_cpha(cpha),
    .i_data(data_in), .i_valid(valid_in), .o_ready(ready), .o_data(data_out),
    .o_valid(valid_out), .o_busy(busy), .o_sclk(sclk), .o_mosi(mosi),
    .o_cs_n(cs_n), .i_miso(miso)
  );

  always #5 clk = ~clk;

  // Tick source: 0 = every cycle, 1 = every 5th cycle, other = random.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase++;
      case (tick_mode)
        0:       tick = 1'b1;
        1:       tick = (phase % 5 == 0);
        default: tick = 1'($urandom_range(0, 1));
      endcase
      tick_cnt += int'(tick);
    end
  end

  // One full transfer with a mode-aware slave model driven from the pins.
  task automatic run_xfer(input logic [W-1:0] word, input logic pol, input logic pha,
                          input logic [W-1:0] sword, input bit hold, input bit perturb,
                          input bit timing, input bit chk_gap, input string name);
    int guard, k, vcount, rises, cs_low, cs_falls, vk, rk, acc_tick, eff_now;
    logic [W-1:0] sout, srx, exp_rx;
    logic psclk, pcs, pready, leading;
    bit done;
    guard = 0;
    while (!ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!ready) begin
      n_bad++;
      $display("FAIL %s ready_wait: ready=%0b required 1 within 2000 cycles", name, ready);
      return;
    end
    data_in = word; cpol = pol; cpha = pha; valid_in = 1'b1;
    acc_tick = int'(tick);
    psclk = sclk; pcs = cs_n; pready = ready;
    sout = '0; srx = '0;
    vcount = 0; rises = 0; cs_low = 0; cs_falls = 0; vk = -1; rk = -1; k = 0; done = 0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cs_n, busy, ready, sclk} !== {1'b0, 1'b1, 1'b0, pol}) begin
      n_bad++;
      $display("FAIL %s after_accept: cs_n/busy/ready/sclk=%b required %b", name,
               {cs_n, busy, ready, sclk}, {1'b0, 1'b1, 1'b0, pol});
    end
    if (chk_gap && have_rise) begin
      eff_now = tick_cnt - int'(tick);
      n_cmp++;
      if (eff_now - eff_rise - acc_tick < 1) begin
        n_bad++;
        $display("FAIL %s cs_gap: ticks with cs_n high=%0d required >=1", name,
                 eff_now - eff_rise - acc_tick);
      end
    end
    if (!hold) valid_in = 1'b0;
    while (!done && k < 4000) begin
      if (pcs && !cs_n) begin
        cs_falls++;
        sout = sword;
        if (!pha) begin
          slave_miso = sout[W-1];
          sout = sout << 1;
        end
      end else if (!cs_n && sclk != psclk) begin
        leading = (sclk != pol);
        if (leading ^ pha) begin
          srx = {srx[W-2:0], mosi};
        end else begin
          slave_miso = sout[W-1];
          sout = sout << 1;
        end
      end
      if (!pcs && !cs_n && !psclk && sclk) rises++;
      if (sclk != psclk && cs_n && pcs && !pready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s idle_sclk: sclk moved to %0b outside IDLE at k=%0d", name, sclk, k);
      end
      if (!cs_n) cs_low++;
      if (valid_out) begin
        vcount++;
        vk = k;
        eff_rise = tick_cnt - int'(tick);
        have_rise = 1;
      end
      if (perturb) begin
        if (k == 40) begin data_in = 8'hFF; valid_in = 1'b1; end
        if (k == 45) valid_in = 1'b0;
        if (k == 50) valid_in = 1'b1;
        if (k == 55) valid_in = 1'b0;
      end
      if (ready) begin
        rk = k;
        done = 1;
      end
      psclk = sclk; pcs = cs_n; pready = ready;
      if (!done) begin
        @(negedge clk);
        k++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: ready=%0b required 1 within 4000 cycles", name, ready);
    end
    exp_rx = loopback ? word : sword;
    n_cmp++;
    if (data_out !== exp_rx) begin
      n_bad++;
      $display("FAIL %s rx_word: o_data=%02h required %02h", name, data_out, exp_rx);
    end
    n_cmp++;
    if (srx !== word) begin
      n_bad++;
      $display("FAIL %s slave_rx: slave got %02h required %02h", name, srx, word);
    end
    n_cmp++;
    if (vcount != 1 || cs_falls != 1) begin
      n_bad++;
      $display("FAIL %s framing: valid pulses=%0d cs falls=%0d required 1/1", name, vcount, cs_falls);
    end
    n_cmp++;
    if (rises != W || sclk !== pol) begin
      n_bad++;
      $display("FAIL %s sclk: rising=%0d idle=%0b required %0d/%0b", name, rises, sclk, W, pol);
    end
    if (timing) begin
      n_cmp++;
      if (vk != 18 || rk != 19 || cs_low != 18) begin
        n_bad++;
        $display("FAIL %s timing: valid@%0d ready@%0d cs_low=%0d required 18/19/18",
                 name, vk, rk, cs_low);
      end
    end
    $display("xfer %s: mode=%0d tx=%02h rx=%02h slave_rx=%02h ticks_valid@%0d", name,
             {pol, pha}, word, data_out, srx, vk);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({cs_n, sclk, mosi, valid_out, busy, ready} !== 6'b100000 || data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_state: pins=%b data=%02h required 100000/00",
               {cs_n, sclk, mosi, valid_out, busy, ready}, data_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%0b required 0 before first edge", ready);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: ready=%0b required 1 after first edge", ready);
    end
    $display("reset: released, ready=%0b", ready);
  endtask

  task automatic test_mode0_loopback();
    tick_mode = 0; loopback = 1'b1;
    run_xfer(8'hA5, 1'b0, 1'b0, 8'hA5, 0, 0, 1, 0, "mode0_loopback");
    loopback = 1'b0;
  endtask

  task automatic test_mode3_slave();
    tick_mode = 0;
    run_xfer(8'hC3, 1'b1, 1'b1, 8'h3C, 0, 0, 1, 0, "mode3_slave");
  endtask

  task automatic test_back_to_back();
    tick_mode = 2;
    have_rise = 0;
    run_xfer(8'h01, 1'b0, 1'b1, W'($urandom), 1, 0, 0, 0, "b2b_mode1");
    run_xfer(8'h80, 1'b1, 1'b0, W'($urandom), 1, 0, 0, 1, "b2b_mode2");
    valid_in = 1'b0;
  endtask

  task automatic test_slow_ticks();
    tick_mode = 1;
    run_xfer(8'h5A, 1'b0, 1'b0, W'($urandom), 0, 1, 0, 0, "slow_ticks");
  endtask

  task automatic test_reset_mid();
    int toggles, guard;
    logic ps;
    tick_mode = 0;
    guard = 0;
    while (!ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    data_in = 8'h96; cpol = 1'b0; cpha = 1'b0; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    ps = sclk; toggles = 0; guard = 0;
    while (toggles < 7 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (sclk != ps) toggles++;
      ps = sclk;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cs_n, sclk, valid_out, busy, ready} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_mid: cs_n/sclk/valid/busy/ready=%b required 10000 (toggles=%0d)",
               {cs_n, sclk, valid_out, busy, ready}, toggles);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_release: ready=%0b valid=%0b required 1/0", ready, valid_out);
    end
    $display("reset_mid: reset after %0d sclk edges", toggles);
    run_xfer(8'hFF, 1'b0, 1'b0, W'($urandom), 0, 0, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] w, s;
    logic p, h;
    tick_mode = 2;
    for (int i = 0; i < 6; i++) begin
      w = W'($urandom);
      s = W'($urandom);
      p = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      run_xfer(w, p, h, s, 0, 0, 0, 0, "random");
    end
  endtask

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; data_in = '0; valid_in = 1'b0;
    slave_miso = 1'b0; loopback = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_mode0_loopback();
    test_mode3_slave();
    test_back_to_back();
    test_slow_ticks();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
